solver_lane_scheduler: RTL and testbench

//  Work scheduler in front of NUM_LANES cube_solver-style lanes. On a run pulse it splits
//  the seed space 0..num_seeds-1 into one job per seed and dispatches jobs to idle lanes.
//  It collects each lane's partial count, accumulates total_found and raises solver_done.

---
 rtl/solver_pkg.sv | 14 +
 rtl/solver_lane_scheduler_rr_arbiter.sv | 41 ++++
 rtl/solver_lane_scheduler.sv | 118 +++++++++++
 tb/tb_solver_lane_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/solver_pkg.sv
// Shared types and default widths for the solver lane scheduler.
package solver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  localparam int unsigned SEED_W = 8;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned TOT_W  = 12;

endpackage

// File: rtl/solver_lane_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr; ptr moves past the grantee.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;

  always_comb begin
    int unsigned idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= PW'((32'(gidx) + 32'd1) % N);
    end
  end

endmodule

// File: rtl/solver_lane_scheduler.sv
// Dispatches one seed job per cycle to idle lanes and accumulates lane results (saturating).
// Optional perf_cycles port/counter enabled by defining SOLVER_PERF_EN.
module solver_lane_scheduler #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned SEED_W    = solver_pkg::SEED_W,
  parameter int unsigned CNT_W     = solver_pkg::CNT_W,
  parameter int unsigned TOT_W     = solver_pkg::TOT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [SEED_W-1:0]           num_seeds,
  output logic [NUM_LANES-1:0]        lane_start,
  output logic [NUM_LANES*SEED_W-1:0] lane_seed,
  input  logic [NUM_LANES-1:0]        lane_done,
  input  logic [NUM_LANES*CNT_W-1:0]  lane_count,
  output logic [NUM_LANES-1:0]        lane_ack,
  output logic [TOT_W-1:0]            total_found,
  output logic                        solver_done
`ifdef SOLVER_PERF_EN
  ,
  output logic [31:0]                 perf_cycles
`endif
);

  import solver_pkg::*;

  localparam int unsigned SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;

  sched_state_e          state;
  logic [SEED_W-1:0]     seeds_q;
  logic [SEED_W-1:0]     next_seed;
  logic [NUM_LANES-1:0]  busy;
  logic [NUM_LANES-1:0]  disp_req;
  logic [NUM_LANES-1:0]  disp_grant;
  logic [NUM_LANES-1:0]  coll_req;
  logic [NUM_LANES-1:0]  coll_grant;
  logic [TOT_W-1:0]      total;
  logic [CNT_W-1:0]      ack_count;
  logic [SUM_W-1:0]      sum;
  logic [TOT_W-1:0]      total_sat;
  logic                  running;
  logic                  more_seeds;
  logic                  accept;
  logic                  finish;

  assign running    = (state == RUN);
  assign more_seeds = (next_seed < seeds_q);
  assign accept     = run && (state != RUN);
  assign disp_req   = (running && more_seeds) ? ~busy : '0;
  assign coll_req   = running ? (lane_done & busy) : '0;
  // Finish looks at busy after this cycle's ack so solver_done rises right after the last ack.
  assign finish     = running && !more_seeds && ((busy & ~coll_grant) == '0);

  rr_arbiter #(.N(NUM_LANES)) u_dispatch (
    .clk   (clk),
    .rst   (rst),
    .req   (disp_req),
    .grant (disp_grant)
  );

  rr_arbiter #(.N(NUM_LANES)) u_collect (
    .clk   (clk),
    .rst   (rst),
    .req   (coll_req),
    .grant (coll_grant)
  );

  always_comb begin
    ack_count = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (coll_grant[i]) ack_count = lane_count[i*CNT_W +: CNT_W];
    end
  end

  assign sum       = SUM_W'(total) + SUM_W'(ack_count);
  assign total_sat = (sum > SUM_W'({TOT_W{1'b1}})) ? '1 : sum[TOT_W-1:0];

  assign lane_start  = disp_grant;
  assign lane_seed   = {NUM_LANES{next_seed}};
  assign lane_ack    = coll_grant;
  assign total_found = total;
  assign solver_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      seeds_q   <= '0;
      next_seed <= '0;
      busy      <= '0;
      total     <= '0;
    end else if (accept) begin
      state     <= RUN;
      seeds_q   <= num_seeds;
      next_seed <= '0;
      busy      <= '0;
      total     <= '0;
    end else if (running) begin
      if (|disp_grant) next_seed <= next_seed + SEED_W'(1);
      if (|coll_grant) total <= total_sat;
      busy <= (busy | disp_grant) & ~coll_grant;
      if (finish) state <= DONE;
    end
  end

`ifdef SOLVER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (running) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_solver_lane_scheduler.sv
// Directed bench for solver_lane_scheduler with behavioural lane models (4 lanes).
module tb_solver_lane_scheduler;

  localparam int unsigned NL = 4;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 12;
  localparam int unsigned TW = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic                run;
  logic [SW-1:0]       num_seeds;
  logic [NL-1:0]       lane_start;
  logic [NL*SW-1:0]    lane_seed;
  logic [NL-1:0]       lane_done;
  logic [NL*CW-1:0]    lane_count;
  logic [NL-1:0]       lane_ack;
  logic [TW-1:0]       total_found;
  logic                solver_done;
`ifdef SOLVER_PERF_EN
  logic [31:0]         perf_cycles;
`endif

  solver_lane_scheduler #(
    .NUM_LANES (NL),
    .SEED_W    (SW),
    .CNT_W     (CW),
    .TOT_W     (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .num_seeds   (num_seeds),
    .lane_start  (lane_start),
    .lane_seed   (lane_seed),
    .lane_done   (lane_done),
    .lane_count  (lane_count),
    .lane_ack    (lane_ack),
    .total_found (total_found),
    .solver_done (solver_done)
`ifdef SOLVER_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total_n = 0;
  int unsigned bad_n   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane model: mode 0 delay 3..10 count seed+1; 1 hold until release; 2 count 4000; 3 long delay
  int unsigned mode = 0;
  logic        release_done = 1'b0;

  function automatic int unsigned lane_delay(input int unsigned m, input int unsigned s);
    case (m)
      0:       return 3 + (s * 3) % 8;
      1:       return 1;
      2:       return 4;
      default: return 10;
    endcase
  endfunction

  function automatic logic [CW-1:0] lane_cnt(input int unsigned m, input int unsigned s);
    if (m == 2) return CW'(4000);
    return CW'(s + 1);
  endfunction

  logic [NL-1:0]    cap_start = '0;
  logic [NL-1:0]    cap_ack   = '0;
  logic [NL*SW-1:0] cap_seed  = '0;

  int st_lane[$];
  int st_seed[$];
  int st_cyc[$];
  int ak_lane[$];
  int ak_cyc[$];

  always @(negedge clk) begin
    cap_start = lane_start;
    cap_ack   = lane_ack;
    cap_seed  = lane_seed;
    for (int i = 0; i < NL; i++) begin
      if (lane_start[i]) begin
        st_lane.push_back(i);
        st_seed.push_back(int'(lane_seed[i*SW +: SW]));
        st_cyc.push_back(cyc);
      end
      if (lane_ack[i]) begin
        ak_lane.push_back(i);
        ak_cyc.push_back(cyc);
      end
    end
  end

  int unsigned rem[NL];
  bit          act[NL];
  int unsigned sd[NL];

  initial begin
    lane_done  = '0;
    lane_count = '0;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      lane_done  = '0;
      lane_count = '0;
      for (int i = 0; i < NL; i++) act[i] = 1'b0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (cap_ack[i]) begin
          lane_done[i] = 1'b0;
          act[i]       = 1'b0;
        end
        if (cap_start[i]) begin
          act[i] = 1'b1;
          sd[i]  = int'(cap_seed[i*SW +: SW]);
          rem[i] = lane_delay(mode, sd[i]);
        end else if (act[i] && !lane_done[i]) begin
          if (rem[i] > 0) rem[i]--;
          else if (mode != 1 || release_done) begin
            lane_done[i]             = 1'b1;
            lane_count[i*CW +: CW]   = lane_cnt(mode, sd[i]);
          end
        end
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_run(input int unsigned n, output int rcyc);
    @(negedge clk);
    num_seeds = SW'(n);
    run       = 1'b1;
    rcyc      = cyc;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int dcyc);
    int n = 0;
    while (!solver_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(solver_done), 32'd1);
    dcyc = cyc;
  endtask

  int rc, dc, sb, ab, r;
  int unsigned mask;

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    num_seeds = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_start", 32'(lane_start), 32'd0);
    check("rst_ack", 32'(lane_ack), 32'd0);
    check("rst_total", 32'(total_found), 32'd0);
    check("rst_done", 32'(solver_done), 32'd0);
`ifdef SOLVER_PERF_EN
    check("rst_perf", perf_cycles, 32'd0);
`endif
    rst = 1'b0;

    // zero seeds: RUN for one cycle, DONE two cycles after run
    sb = st_lane.size();
    pulse_run(0, rc);
    check("z_done_run", 32'(solver_done), 32'd0);
    @(negedge clk);
    check("z_done", 32'(solver_done), 32'd1);
    check("z_total", 32'(total_found), 32'd0);
    check("z_starts", 32'(st_lane.size() - sb), 32'd0);
`ifdef SOLVER_PERF_EN
    check("z_perf", perf_cycles, 32'd1);
`endif

    // six seeds with varied latency
    mode = 0;
    sb   = st_lane.size();
    pulse_run(6, rc);
    wait_done("s6_timeout", 300, dc);
    check("s6_total", 32'(total_found), 32'd21);
    check("s6_starts", 32'(st_lane.size() - sb), 32'd6);
    mask = 0;
    for (int k = sb; k < st_lane.size(); k++) mask |= (32'd1 << st_seed[k]);
    check("s6_seeds", mask, 32'h3f);
`ifdef SOLVER_PERF_EN
    check("s6_perf", perf_cycles, 32'(dc - rc - 1));
`endif
    repeat (5) @(negedge clk);
    check("s6_hold", 32'(solver_done), 32'd1);
    check("s6_total_hold", 32'(total_found), 32'd21);
`ifdef SOLVER_PERF_EN
    check("s6_perf_hold", perf_cycles, 32'(dc - rc - 1));
`endif

    // all four lanes finish together: acks one per cycle, restarts the cycle after ack
    reset_dut();
    mode         = 1;
    release_done = 1'b0;
    sb           = st_lane.size();
    ab           = ak_lane.size();
    pulse_run(8, rc);
    repeat (12) @(negedge clk);
    check("rr_hold", 32'(ak_lane.size() - ab), 32'd0);
    release_done = 1'b1;
    r            = cyc + 1;
    wait_done("rr_timeout", 300, dc);
    check("rr_total", 32'(total_found), 32'd36);
    check("rr_nacks", 32'(ak_lane.size() - ab), 32'd8);
    check("rr_nstarts", 32'(st_lane.size() - sb), 32'd8);
    if (ak_lane.size() - ab >= 4 && st_lane.size() - sb >= 8) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_ack_lane%0d", k), 32'(ak_lane[ab+k]), 32'(k));
        check($sformatf("rr_ack_cyc%0d", k), 32'(ak_cyc[ab+k]), 32'(r + k));
        check($sformatf("rr_re_lane%0d", k), 32'(st_lane[sb+4+k]), 32'(k));
        check($sformatf("rr_re_cyc%0d", k), 32'(st_cyc[sb+4+k]), 32'(r + 1 + k));
        check($sformatf("rr_re_seed%0d", k), 32'(st_seed[sb+4+k]), 32'(4 + k));
      end
    end
    release_done = 1'b0;

    // saturation
    mode = 2;
    pulse_run(3, rc);
    wait_done("sat_timeout", 300, dc);
    check("sat_total", 32'(total_found), 32'd4095);
    check("sat_done", 32'(solver_done), 32'd1);

    // reset mid-run, then a clean run with an ignored second run pulse
    mode = 3;
    pulse_run(5, rc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_start", 32'(lane_start), 32'd0);
    check("mr_ack", 32'(lane_ack), 32'd0);
    check("mr_total", 32'(total_found), 32'd0);
    check("mr_done", 32'(solver_done), 32'd0);
`ifdef SOLVER_PERF_EN
    check("mr_perf", perf_cycles, 32'd0);
`endif
    rst  = 1'b0;
    mode = 0;
    sb   = st_lane.size();
    pulse_run(2, rc);
    @(negedge clk);
    num_seeds = SW'(7);
    run       = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_done("mr_timeout", 300, dc);
    check("mr2_total", 32'(total_found), 32'd3);
    check("mr2_starts", 32'(st_lane.size() - sb), 32'd2);
`ifdef SOLVER_PERF_EN
    check("mr2_perf", perf_cycles, 32'(dc - rc - 1));
`endif

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
